// File: rtl/ili9341_pkg.sv
// Shared types and constants for the ILI9341 write-bus arbiter and its requesters.
// Holds the arbiter state encoding and the panel command bytes the sequencers emit.
package ili9341_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // Largest of the three timing parameters sizes the shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/ili9341_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
// last_served resets to 1 so requester 0 takes the first tie.
module rr_arbiter2
    import ili9341_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       served_i,
    output logic [1:0] grant_o
);

    logic last_served_q;
    logic last_served_d;

    // Next value of the last-served owner, loaded when a packet completes.
    always_comb begin
        last_served_d = last_served_q;
        if (update_i) begin
            last_served_d = served_i;
        end else begin
            last_served_d = last_served_q;
        end
    end

    // Last-served register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_served_q <= 1'b1;
        end else begin
            last_served_q <= last_served_d;
        end
    end

    // One-hot pick from the current requests.
    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_served_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ili9341_bus_arbiter.sv
// Packet-atomic round-robin sharing of the ILI9341 8080 write bus between two
// byte streams, generating registered CS/CD/WR strobes and the data bus.
module ili9341_bus_arbiter
    import ili9341_pkg::*;
#(
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2,
    parameter int CS_GAP_CYCLES  = 1
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic [1:0] in_valid,
    input  logic [7:0] in_data0,
    input  logic [7:0] in_data1,
    input  logic [1:0] in_cd,
    input  logic [1:0] in_last,
    output logic [1:0] out_ready,
    output logic [1:0] out_grant,
    output logic       out_busy,
    output logic       out_cs,
    output logic       out_cd,
    output logic       out_wr,
    output logic       out_rd,
    output logic [7:0] out_data
);

    localparam int CNT_W = $clog2(max3(WR_LOW_CYCLES, WR_HIGH_CYCLES, CS_GAP_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] LO_LOAD  = CNT_W'(WR_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HI_LOAD  = CNT_W'(WR_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(CS_GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       grant_q, grant_d;
    logic [7:0]       data_q, data_d;
    logic             cd_q, cd_d;
    logic             last_q, last_d;
    logic             cs_q, cs_d;
    logic             wr_q, wr_d;
    logic             busy_q, busy_d;
    logic [1:0]       pick_s;
    logic             xfer_s;
    logic             served_upd_s;

    rr_arbiter2 u_rr (
        .clk_i    (in_clk),
        .rst_n_i  (in_rst_n),
        .req_i    (in_valid),
        .update_i (served_upd_s),
        .served_i (grant_q[1]),
        .grant_o  (pick_s)
    );

    assign xfer_s    = (state_q == ST_LOAD) && (|(in_valid & grant_q));
    assign out_ready = (state_q == ST_LOAD) ? grant_q : 2'b00;

    // Strobes are registered from the next state so they change on the same edge as the FSM.
    assign cs_d   = (state_d == ST_IDLE) || (state_d == ST_GAP);
    assign wr_d   = (state_d != ST_WR_LO);
    assign busy_d = (state_d != ST_IDLE);

    // Next-state, cycle counter and byte latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        data_d       = data_q;
        cd_d         = cd_q;
        last_d       = last_q;
        served_upd_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|in_valid) begin
                    grant_d = pick_s;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    data_d  = grant_q[1] ? in_data1 : in_data0;
                    cd_d    = |(in_cd & grant_q);
                    last_d  = |(in_last & grant_q);
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_SETUP: begin
                cnt_d   = LO_LOAD;
                state_d = ST_WR_LO;
            end
            ST_WR_LO: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = HI_LOAD;
                    state_d = ST_WR_HI;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WR_HI: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = GAP_LOAD;
                    state_d = last_q ? ST_GAP : ST_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_ZERO) begin
                    served_upd_s = 1'b1;
                    grant_d      = 2'b00;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latch and registered panel outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            grant_q <= 2'b00;
            data_q  <= 8'h00;
            cd_q    <= 1'b1;
            last_q  <= 1'b0;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            cd_q    <= cd_d;
            last_q  <= last_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
        end
    end

    assign out_grant = grant_q;
    assign out_busy  = busy_q;
    assign out_cs    = cs_q;
    assign out_cd    = cd_q;
    assign out_wr    = wr_q;
    assign out_rd    = 1'b1;
    assign out_data  = data_q;

endmodule

// File: tb/tb_ili9341_bus_arbiter.sv
// Scoreboard bench for ili9341_bus_arbiter: expected bytes are queued per requester
// as they are offered and matched against bytes seen on the panel pins.
module tb_ili9341_bus_arbiter;
    import ili9341_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       cd;
        logic [1:0] grant;
        int         lo;
        logic       cs_low;
        logic       stable;
        int         fall_cyc;
    } obs_t;

    typedef struct {
        logic [7:0] data;
        logic       cd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v0 = 1'b0, v1 = 1'b0, cd0 = 1'b0, cd1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic [1:0] valid_s, cd_s, last_s;
    logic [1:0] ready, grant;
    logic       busy, cs, cdo, wr, rd;
    logic [7:0] dout;

    assign valid_s = {v1, v0};
    assign cd_s    = {cd1, cd0};
    assign last_s  = {l1, l0};

    ili9341_bus_arbiter dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(valid_s), .in_data0(d0), .in_data1(d1),
        .in_cd(cd_s), .in_last(last_s), .out_ready(ready), .out_grant(grant), .out_busy(busy),
        .out_cs(cs), .out_cd(cdo), .out_wr(wr), .out_rd(rd), .out_data(dout)
    );

    logic [1:0] p_valid = 2'b00, p_cd = 2'b00, p_last = 2'b00;
    logic [7:0] p_d0 = 8'h00, p_d1 = 8'h00;
    logic [1:0] p_ready, p_grant;
    logic       p_busy, p_cs, p_cdo, p_wr, p_rd;
    logic [7:0] p_dout;

    ili9341_bus_arbiter #(.WR_LOW_CYCLES(1), .WR_HIGH_CYCLES(3), .CS_GAP_CYCLES(4)) dut_p (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(p_valid), .in_data0(p_d0), .in_data1(p_d1),
        .in_cd(p_cd), .in_last(p_last), .out_ready(p_ready), .out_grant(p_grant), .out_busy(p_busy),
        .out_cs(p_cs), .out_cd(p_cdo), .out_wr(p_wr), .out_rd(p_rd), .out_data(p_dout)
    );

    int n_cmp = 0;
    int n_err = 0;

    obs_t       obs_q[$];
    exp_t       exp0[$];
    exp_t       exp1[$];
    int         gap_q[$];
    int         rise_q[$];
    logic [1:0] glog[$];

    // Pin monitor: records each WR pulse, each new owner and each packet's CS-high span.
    int         cyc = 0;
    logic       prev_wr = 1'b1, prev_cs = 1'b1, prev_busy = 1'b0;
    logic [1:0] prev_grant = 2'b00;
    obs_t       cur;
    int         gapc = 0, rises = 0;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_wr && !wr) begin
                cur.data = dout; cur.cd = cdo; cur.grant = grant; cur.lo = 1;
                cur.cs_low = !cs; cur.stable = 1'b1; cur.fall_cyc = cyc;
            end else if (!prev_wr && !wr) begin
                cur.lo++;
                if (dout !== cur.data || cdo !== cur.cd) cur.stable = 1'b0;
                if (cs) cur.cs_low = 1'b0;
            end else if (!prev_wr && wr) begin
                if (dout !== cur.data || cdo !== cur.cd) cur.stable = 1'b0;
                obs_q.push_back(cur);
            end
            if (grant != 2'b00 && prev_grant == 2'b00) glog.push_back(grant);
            if (busy && !prev_busy) begin gapc = 0; rises = 0; end
            if (busy) begin
                if (cs) gapc++;
                if (cs && !prev_cs) rises++;
            end
            if (!busy && prev_busy) begin gap_q.push_back(gapc); rise_q.push_back(rises); end
            prev_wr = wr; prev_cs = cs; prev_busy = busy; prev_grant = grant;
        end
    end

    task automatic clear_logs();
        obs_q.delete(); exp0.delete(); exp1.delete();
        gap_q.delete(); rise_q.delete(); glog.delete();
    endtask

    // Offers one packet from requester src (byte i in bytes[8*i+:8], cd in cdm[i]);
    // optionally drops valid for 10 clocks after byte stall_at.
    task automatic send_pkt(input int src, input int n, input logic [31:0] bytes,
                            input logic [3:0] cdm, input int stall_at);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            logic       c, l;
            int         t;
            b = bytes[8*i +: 8];
            c = cdm[i];
            l = (i == n - 1);
            if (src == 0) begin
                d0 = b; cd0 = c; l0 = l; v0 = 1'b1; exp0.push_back('{b, c});
            end else begin
                d1 = b; cd1 = c; l1 = l; v1 = 1'b1; exp1.push_back('{b, c});
            end
            t = 0;
            do begin @(negedge clk); t++; end while (!ready[src] && t < 400);
            if (!ready[src]) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout src%0d byte%0d: ready=%b want 1", src, i, ready[src]);
            end
            @(posedge clk); #1;
            if (src == 0) v0 = 1'b0; else v1 = 1'b0;
            if (i == stall_at) begin
                repeat (10) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cs, wr, rd, cdo, dout, grant, busy, ready} !== {4'b1111, 8'h00, 2'b00, 1'b0, 2'b00}) begin
            n_err++;
            $display("FAIL reset_vals: cs=%b wr=%b rd=%b cd=%b data=%h grant=%b busy=%b ready=%b want 1 1 1 1 00 00 0 00",
                     cs, wr, rd, cdo, dout, grant, busy, ready);
        end
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cs, wr, busy, grant} !== {1'b1, 1'b1, 1'b0, 2'b00}) begin
            n_err++;
            $display("FAIL idle_hold: cs=%b wr=%b busy=%b grant=%b want 1 1 0 00", cs, wr, busy, grant);
        end
        clear_logs();
    endtask

    task automatic test_simultaneous();
        obs_t o; exp_t e; logic ok;
        fork
            send_pkt(0, 2, 32'h0000_002A, 4'b0000, -1);
            send_pkt(1, 3, 32'h00C3_B2A1, 4'b0110, -1);
        join
        fork
            send_pkt(0, 1, {24'h0, CMD_RAMWR}, 4'b0000, -1);
            send_pkt(1, 2, {16'h0, 8'h77, CMD_PASET}, 4'b0010, -1);
        join
        repeat (15) @(negedge clk);
        n_cmp++;
        if (glog.size() != 4 || glog[0] !== 2'b01 || glog[1] !== 2'b10 || glog[2] !== 2'b01 || glog[3] !== 2'b10) begin
            n_err++;
            $display("FAIL sim_grant_order: got %0d grants first=%b want 01,10,01,10",
                     glog.size(), (glog.size() > 0) ? glog[0] : 2'bxx);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); ok = 1'b0;
            if (o.grant == 2'b01 && exp0.size() > 0) begin e = exp0.pop_front(); ok = 1'b1; end
            else if (o.grant == 2'b10 && exp1.size() > 0) begin e = exp1.pop_front(); ok = 1'b1; end
            else begin ok = 1'b0; end
            n_cmp++;
            if (!ok || o.data !== e.data || o.cd !== e.cd || o.lo != 2 || !o.cs_low || !o.stable) begin
                n_err++;
                $display("FAIL sim_byte: got data=%h cd=%b grant=%b lo=%0d cs_low=%b stable=%b want data=%h cd=%b lo=2 cs_low=1 stable=1",
                         o.data, o.cd, o.grant, o.lo, o.cs_low, o.stable, e.data, e.cd);
            end
        end
        n_cmp++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            n_err++;
            $display("FAIL sim_missing: left %0d/%0d bytes want 0/0", exp0.size(), exp1.size());
        end
        clear_logs();
    endtask

    task automatic test_single();
        obs_t o; exp_t e; logic ok; int prev_fall;
        send_pkt(0, 3, 32'h00EF_002A, 4'b0110, -1);
        repeat (15) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 3) begin
            n_err++;
            $display("FAIL single_count: got %0d WR pulses want 3", obs_q.size());
        end
        prev_fall = -1;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); ok = 1'b0;
            if (o.grant == 2'b01 && exp0.size() > 0) begin e = exp0.pop_front(); ok = 1'b1; end
            else begin ok = 1'b0; end
            n_cmp++;
            if (!ok || o.data !== e.data || o.cd !== e.cd || o.lo != 2 || !o.cs_low || !o.stable) begin
                n_err++;
                $display("FAIL single_byte: got data=%h cd=%b grant=%b lo=%0d cs_low=%b stable=%b want data=%h cd=%b grant=01 lo=2 cs_low=1 stable=1",
                         o.data, o.cd, o.grant, o.lo, o.cs_low, o.stable, e.data, e.cd);
            end
            if (prev_fall >= 0) begin
                n_cmp++;
                if (o.fall_cyc - prev_fall != 6) begin
                    n_err++;
                    $display("FAIL single_period: got %0d want 6", o.fall_cyc - prev_fall);
                end
            end
            prev_fall = o.fall_cyc;
        end
        n_cmp++;
        if (gap_q.size() != 1 || gap_q[0] != 1 || rise_q[0] != 1) begin
            n_err++;
            $display("FAIL single_cs: packets=%0d gap=%0d cs_rises=%0d want 1 1 1",
                     gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1, (rise_q.size() > 0) ? rise_q[0] : -1);
        end
        clear_logs();
    endtask

    task automatic test_atomicity();
        obs_t o; exp_t e; logic ok; int viol;
        viol = 0;
        fork
            send_pkt(1, 4, 32'h4433_2211, 4'b1111, -1);
            begin
                repeat (8) @(posedge clk);
                #1;
                send_pkt(0, 1, {24'h0, CMD_CASET}, 4'b0000, -1);
            end
            begin
                repeat (60) begin
                    @(negedge clk);
                    if (ready[0] && grant[1]) viol++;
                    if (v0 && ready[0] && exp1.size() > 0 && obs_q.size() < 4) viol++;
                end
            end
        join
        repeat (15) @(negedge clk);
        n_cmp++;
        if (viol != 0) begin
            n_err++;
            $display("FAIL atom_ready0: got %0d early ready[0] cycles want 0", viol);
        end
        n_cmp++;
        if (glog.size() != 2 || glog[0] !== 2'b10 || glog[1] !== 2'b01) begin
            n_err++;
            $display("FAIL atom_order: got %0d grants first=%b want 10,01", glog.size(), (glog.size() > 0) ? glog[0] : 2'bxx);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); ok = 1'b0;
            if (o.grant == 2'b01 && exp0.size() > 0) begin e = exp0.pop_front(); ok = 1'b1; end
            else if (o.grant == 2'b10 && exp1.size() > 0) begin e = exp1.pop_front(); ok = 1'b1; end
            else begin ok = 1'b0; end
            n_cmp++;
            if (!ok || o.data !== e.data || o.cd !== e.cd || o.lo != 2 || !o.cs_low) begin
                n_err++;
                $display("FAIL atom_byte: got data=%h cd=%b grant=%b lo=%0d want data=%h cd=%b lo=2",
                         o.data, o.cd, o.grant, o.lo, e.data, e.cd);
            end
        end
        n_cmp++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            n_err++;
            $display("FAIL atom_missing: left %0d/%0d bytes want 0/0", exp0.size(), exp1.size());
        end
        clear_logs();
    endtask

    task automatic test_stall();
        obs_t o0, o1; exp_t e0, e1;
        send_pkt(0, 2, 32'h0000_5A2C, 4'b0010, 0);
        repeat (15) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 2 || exp0.size() != 2) begin
            n_err++;
            $display("FAIL stall_count: got %0d WR pulses want 2", obs_q.size());
        end else begin
            o0 = obs_q.pop_front(); o1 = obs_q.pop_front();
            e0 = exp0.pop_front();  e1 = exp0.pop_front();
            n_cmp++;
            if (o0.data !== e0.data || o0.cd !== e0.cd || o1.data !== e1.data || o1.cd !== e1.cd) begin
                n_err++;
                $display("FAIL stall_bytes: got %h/%b %h/%b want %h/%b %h/%b",
                         o0.data, o0.cd, o1.data, o1.cd, e0.data, e0.cd, e1.data, e1.cd);
            end
            n_cmp++;
            if (o1.fall_cyc - o0.fall_cyc != 11) begin
                n_err++;
                $display("FAIL stall_resume: got fall spacing %0d want 11", o1.fall_cyc - o0.fall_cyc);
            end
        end
        n_cmp++;
        if (rise_q.size() != 1 || rise_q[0] != 1 || gap_q[0] != 1) begin
            n_err++;
            $display("FAIL stall_cs: packets=%0d cs_rises=%0d want 1 1", rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1);
        end
        clear_logs();
    endtask

    task automatic test_reset_midop();
        int t;
        d0 = 8'hA5; cd0 = 1'b1; l0 = 1'b0; v0 = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (wr !== 1'b0 && t < 100);
        n_cmp++;
        if (wr !== 1'b0) begin
            n_err++;
            $display("FAIL midop_wr_low: wr=%b want 0", wr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cs, wr, rd, cdo, dout, grant, busy, ready} !== {4'b1111, 8'h00, 2'b00, 1'b0, 2'b00}) begin
            n_err++;
            $display("FAIL midop_reset_vals: cs=%b wr=%b rd=%b cd=%b data=%h grant=%b busy=%b ready=%b want 1 1 1 1 00 00 0 00",
                     cs, wr, rd, cdo, dout, grant, busy, ready);
        end
        v0 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_logs();
        fork
            send_pkt(0, 1, {24'h0, CMD_PASET}, 4'b0000, -1);
            send_pkt(1, 1, {24'h0, CMD_CASET}, 4'b0000, -1);
        join
        repeat (15) @(negedge clk);
        n_cmp++;
        if (glog.size() != 2 || glog[0] !== 2'b01 || glog[1] !== 2'b10) begin
            n_err++;
            $display("FAIL midop_tie: got %0d grants first=%b want 01,10", glog.size(), (glog.size() > 0) ? glog[0] : 2'bxx);
        end
        n_cmp++;
        if (obs_q.size() != 2 || obs_q[0].data !== CMD_PASET || obs_q[1].data !== CMD_CASET) begin
            n_err++;
            $display("FAIL midop_bytes: got %0d bytes first=%h want 2B then 2A",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 8'hxx);
        end
        clear_logs();
    endtask

    task automatic test_param_sweep();
        int   fall_c[$], rise_c[$];
        int   cs_rise_c, gp, xfers;
        logic pend, pw, pc;
        cs_rise_c = -1; gp = 0; xfers = 0; pend = 1'b0; pw = 1'b1; pc = 1'b1;
        p_d0 = 8'h11; p_cd = 2'b01; p_last = 2'b00; p_valid = 2'b01;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (pw && !p_wr) fall_c.push_back(c);
            if (!pw && p_wr) rise_c.push_back(c);
            if (!pc && p_cs && cs_rise_c < 0) cs_rise_c = c;
            if (p_cs && p_busy) gp++;
            pw = p_wr; pc = p_cs;
            if (pend) begin
                xfers++;
                pend = 1'b0;
                if (xfers == 1) begin p_d0 = 8'h22; p_last = 2'b01; end
                else begin p_valid = 2'b00; p_last = 2'b00; end
            end
            if (p_ready[0] && p_valid[0]) pend = 1'b1;
        end
        n_cmp++;
        if (fall_c.size() != 2 || rise_c.size() != 2) begin
            n_err++;
            $display("FAIL sweep_count: got %0d falls %0d rises want 2 2", fall_c.size(), rise_c.size());
        end else begin
            n_cmp++;
            if (rise_c[0] - fall_c[0] != 1 || rise_c[1] - fall_c[1] != 1) begin
                n_err++;
                $display("FAIL sweep_wr_low: got %0d,%0d want 1,1", rise_c[0] - fall_c[0], rise_c[1] - fall_c[1]);
            end
            n_cmp++;
            if (fall_c[1] - fall_c[0] != 6) begin
                n_err++;
                $display("FAIL sweep_period: got %0d want 6", fall_c[1] - fall_c[0]);
            end
            n_cmp++;
            if (cs_rise_c - rise_c[1] != 3) begin
                n_err++;
                $display("FAIL sweep_wr_high: got %0d want 3", cs_rise_c - rise_c[1]);
            end
        end
        n_cmp++;
        if (gp != 4) begin
            n_err++;
            $display("FAIL sweep_cs_gap: got %0d want 4", gp);
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single();
        test_atomicity();
        test_stall();
        test_reset_midop();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
